calc_display_driver: RTL and testbench
======================================

Name: calc_display_driver

Overview:
Output side of the calculator's user interface: presents operand1, operand2 and the latched result on a 4-digit, common-anode, multiplexed 7-segment display.
- Consumes the operand bus and the selecting_op1/selecting_op2 status flags from operand entry.
- Consumes the result/result_valid pair from the ALU.
- Scans digits at a fixed refresh rate and blinks the digit currently being entered.
- Blanks the result digits until a result exists.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit stays lit (min 2)
BLINK_DIV, 25000000, clock cycles per blink half-period (min 2)

Ports:
clk  input  1  system clock
reset  input  1  reset
operand1  input  4  first operand (hex digit)
operand2  input  4  second operand (hex digit)
selecting_op1  input  1  operand 1 entry in progress
selecting_op2  input  1  operand 2 entry in progress
result  input  8  ALU result
result_valid  input  1  one-cycle strobe, result is valid
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
an  output  4  digit anodes, active-low, an[0] rightmost
dp  output  1  decimal point, active-low

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high; all state updates on posedge clk.
- Reset values (all outputs registered):
  - seg=7'h7F, an=4'hF, dp=1
  - refresh_cnt=0, digit_idx=0, blink_cnt=0, blink_on=1
  - result_reg=0, have_result=0
- Refresh scan:
  - refresh_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On the terminal count, digit_idx increments 0→1→2→3→0.
- Registered output stage: seg/an/dp reflect the digit_idx value of the previous cycle (1-cycle latency).
  - After reset deassertion, first lit pattern appears on the 2nd rising edge.
  - Exactly one an bit is low at any time after that.
- Digit map:
  - idx0 → an=4'b1110, result_reg[3:0]
  - idx1 → an=4'b1101, result_reg[7:4]
  - idx2 → an=4'b1011, operand2
  - idx3 → an=4'b0111, operand1
- Hex encoding (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Blank=1111111.
- Result latch:
  - result_valid=1 → result_reg<=result, have_result<=1.
  - Rising edge of selecting_op1 (registered 1-cycle history) → have_result<=0; result_reg is held.
  - Both in the same cycle: the clear wins; result_reg still loads.
- Blanking:
  - idx0/idx1 show Blank while have_result=0.
  - idx3 shows Blank while selecting_op1=1 and blink_on=0.
  - idx2 shows Blank while selecting_op2=1 and blink_on=0.
  - Blanked digits keep their anode active (an pattern unchanged); only seg goes to 7'h7F.
- Blink timer:
  - Runs only while selecting_op1|selecting_op2.
  - blink_cnt counts 0..BLINK_DIV-1; on the terminal count it wraps and blink_on toggles.
  - While neither select is high: blink_cnt<=0, blink_on<=1, so each entry phase starts visible.
  - Both selects high (illegal upstream): both operand digits blink in phase.
- Decimal point: dp=0 only when displaying idx2 and have_result=1; otherwise 1.
- Operand inputs are not latched; display tracks them live (entry block holds them stable).
- Reset mid-scan or mid-blink returns to the reset values on the next edge, regardless of other inputs.

Test Plan:
(All with REFRESH_DIV=4, BLINK_DIV=8.)
1. Reset held 3 cycles, then released:
   - an=4'hF, seg=7'h7F during reset.
   - 2nd edge after release: an=4'b1110, seg=1111111 (no result yet).
   - an advances every 4 cycles through 1101, 1011, 0111, 1110.
2. operand1=4'hA, operand2=4'h3, selects low, no result:
   - idx3 seg=0001000, idx2 seg=0110000.
   - idx1/idx0 blank; dp=1 throughout.
3. result=8'h5C with a 1-cycle result_valid pulse:
   - idx1 seg=0010010, idx0 seg=1000110.
   - dp=0 only while an=4'b1011.
4. selecting_op1=1 held 40 cycles, operand1=4'h7:
   - idx3 alternates 1111000 / blank every 8 cycles, starting visible.
   - idx2 never blanks.
   - Drop selecting_op1: blink_on returns to 1 next cycle.
5. Pulse result_valid (result=8'h12), later raise selecting_op1: result digits blank 1 cycle after the rise. Also assert result_valid in the same cycle as a selecting_op1 rise: have_result=0 and result_reg=new value.
6. Assert reset for 1 cycle mid-blink at digit idx2: next edge yields reset values; scan restarts at idx0.

Source files
------------

// File: rtl/calc_display_driver.sv
// Four-digit multiplexed 7-segment driver for the calculator: shows operand1,
// operand2 and the latched ALU result, blinking whichever operand is being entered.
module calc_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] operand1,
  input  logic [3:0] operand2,
  input  logic       selecting_op1,
  input  logic       selecting_op2,
  input  logic [7:0] result,
  input  logic       result_valid,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_BLANK    = 7'h7F;

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic [7:0]    result_reg;
  logic          have_result;
  logic          sel1_d;
  logic          vld_p0;

  logic [3:0]    digit_val;
  logic          digit_blank;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;
  logic          dp_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Blink phase restarts visible every time an entry phase begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (selecting_op1 || selecting_op2) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end else begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end
  end

  // Starting a new operand1 entry retires the old result, even if a new one lands now.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_reg  <= '0;
      have_result <= 1'b0;
      sel1_d      <= 1'b0;
    end else begin
      sel1_d <= selecting_op1;
      if (result_valid) result_reg <= result;
      if (selecting_op1 && !sel1_d) have_result <= 1'b0;
      else if (result_valid)        have_result <= 1'b1;
    end
  end

  always_comb begin
    digit_val   = 4'h0;
    digit_blank = 1'b0;
    an_nxt      = 4'hF;
    dp_nxt      = 1'b1;
    case (digit_idx)
      2'd0: begin
        an_nxt      = 4'b1110;
        digit_val   = result_reg[3:0];
        digit_blank = ~have_result;
      end
      2'd1: begin
        an_nxt      = 4'b1101;
        digit_val   = result_reg[7:4];
        digit_blank = ~have_result;
      end
      2'd2: begin
        an_nxt      = 4'b1011;
        digit_val   = operand2;
        digit_blank = selecting_op2 && !blink_on;
        dp_nxt      = ~have_result;
      end
      default: begin
        an_nxt      = 4'b0111;
        digit_val   = operand1;
        digit_blank = selecting_op1 && !blink_on;
      end
    endcase
    seg_nxt = digit_blank ? SEG_BLANK : hex_to_seg(digit_val);
  end

  // ---- stage p0: registered outputs, held dark for the first cycle out of reset ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      seg    <= SEG_BLANK;
      an     <= 4'hF;
      dp     <= 1'b1;
    end else begin
      vld_p0 <= 1'b1;
      if (vld_p0) begin
        seg <= seg_nxt;
        an  <= an_nxt;
        dp  <= dp_nxt;
      end else begin
        seg <= SEG_BLANK;
        an  <= 4'hF;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calc_display_driver.sv
// Directed bench for calc_display_driver with REFRESH_DIV=4, BLINK_DIV=8:
// a vector table for digit content plus hand-timed reset, blink and latch sequences.
module tb_calc_display_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] operand1 = 4'h0;
  logic [3:0] operand2 = 4'h0;
  logic       selecting_op1 = 1'b0;
  logic       selecting_op2 = 1'b0;
  logic [7:0] result = 8'h00;
  logic       result_valid = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int vec_cnt = 0;
  int miss_cnt = 0;

  calc_display_driver #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
    .clk(clk), .reset(reset),
    .operand1(operand1), .operand2(operand2),
    .selecting_op1(selecting_op1), .selecting_op2(selecting_op2),
    .result(result), .result_valid(result_valid),
    .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      op1;
    logic [3:0]      op2;
    logic [7:0]      res;
    logic            rv;
    logic [3:0][6:0] exp_seg;  // indexed by digit idx
    logic            hr;       // result expected shown (dp lit at idx2)
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int idx;
    int n;
    logic [6:0] exp_s;

    vecs[0] = '{op1:4'hA, op2:4'h3, res:8'h00, rv:1'b0,
                exp_seg:{7'b0001000, 7'b0110000, 7'h7F, 7'h7F}, hr:1'b0};
    vecs[1] = '{op1:4'hA, op2:4'h3, res:8'h5C, rv:1'b1,
                exp_seg:{7'b0001000, 7'b0110000, 7'b0010010, 7'b1000110}, hr:1'b1};
    vecs[2] = '{op1:4'h0, op2:4'hF, res:8'hE9, rv:1'b1,
                exp_seg:{7'b1000000, 7'b0001110, 7'b0000110, 7'b0010000}, hr:1'b1};
    vecs[3] = '{op1:4'h8, op2:4'hD, res:8'h6B, rv:1'b1,
                exp_seg:{7'b0000000, 7'b0100001, 7'b0000010, 7'b0000011}, hr:1'b1};
    vecs[4] = '{op1:4'h4, op2:4'h7, res:8'hA1, rv:1'b1,
                exp_seg:{7'b0011001, 7'b1111000, 7'b0001000, 7'b1111001}, hr:1'b1};
    vecs[5] = '{op1:4'h2, op2:4'hC, res:8'h5E, rv:1'b0,
                exp_seg:{7'b0100100, 7'b1000110, 7'b0001000, 7'b1111001}, hr:1'b1};

    // Reset held three cycles, then scan timing after release
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'h1);
    end
    reset = 1'b0;
    tick();
    chk("first_edge_dark_an", 32'(an), 32'hF);
    tick();
    chk("second_edge_an", 32'(an), 32'b1110);
    chk("second_edge_seg", 32'(seg), 32'h7F);
    for (n = 3; n <= 17; n++) begin
      tick();
      case (n)
        4:  chk("scan_n4_an", 32'(an), 32'b1110);
        5:  chk("scan_n5_an", 32'(an), 32'b1101);
        9:  chk("scan_n9_an", 32'(an), 32'b1011);
        13: chk("scan_n13_an", 32'(an), 32'b0111);
        17: chk("scan_n17_an", 32'(an), 32'b1110);
        default: ;
      endcase
    end

    // Digit content table
    for (int v = 0; v < 6; v++) begin
      operand1 = vecs[v].op1;
      operand2 = vecs[v].op2;
      result = vecs[v].res;
      result_valid = vecs[v].rv;
      tick();
      result_valid = 1'b0;
      result = 8'hFF;
      tick();
      for (int c = 0; c < 16; c++) begin
        tick();
        idx = an_idx(an);
        chk($sformatf("v%0d_one_anode", v), 32'(idx >= 0), 32'h1);
        if (idx >= 0) begin
          chk($sformatf("v%0d_seg_idx%0d", v, idx), 32'(seg), 32'(vecs[v].exp_seg[idx]));
          chk($sformatf("v%0d_dp_idx%0d", v, idx), 32'(dp),
              32'((idx == 2 && vecs[v].hr) ? 1'b0 : 1'b1));
        end
      end
    end

    // Operand1 blink: select rises after edge 6, held through edge 46
    do_reset();
    operand1 = 4'h7;
    operand2 = 4'h3;
    for (n = 1; n <= 6; n++) tick();
    selecting_op1 = 1'b1;
    for (n = 7; n <= 46; n++) begin
      tick();
      if (an == 4'b0111) begin
        exp_s = ((((n - 7) / 8) % 2) == 0) ? 7'b1111000 : 7'h7F;
        chk($sformatf("blink_idx3_n%0d", n), 32'(seg), 32'(exp_s));
      end
      if (an == 4'b1011)
        chk($sformatf("blink_idx2_n%0d", n), 32'(seg), 32'b0110000);
    end
    chk("blink_on_before_drop", 32'(dut.blink_on), 32'h0);
    selecting_op1 = 1'b0;
    tick();
    chk("blink_on_after_drop", 32'(dut.blink_on), 32'h1);
    chk("after_drop_an", 32'(an), 32'b0111);
    chk("after_drop_seg", 32'(seg), 32'b1111000);

    // Result latch and clear on operand1 entry
    do_reset();
    result = 8'h12;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    tick();
    chk("res12_idx0_an", 32'(an), 32'b1110);
    chk("res12_idx0_seg", 32'(seg), 32'b0100100);
    tick();
    tick();
    tick();
    chk("res12_idx1_an", 32'(an), 32'b1101);
    chk("res12_idx1_seg", 32'(seg), 32'b1111001);
    selecting_op1 = 1'b1;
    tick();
    chk("rise_same_cycle_seg", 32'(seg), 32'b1111001);
    tick();
    chk("rise_next_an", 32'(an), 32'b1101);
    chk("rise_next_seg_blank", 32'(seg), 32'h7F);
    chk("rise_have_result", 32'(dut.have_result), 32'h0);
    chk("rise_result_held", 32'(dut.result_reg), 32'h12);
    selecting_op1 = 1'b0;
    tick();
    result = 8'h99;
    result_valid = 1'b1;
    tick();
    chk("reload_have_result", 32'(dut.have_result), 32'h1);
    chk("reload_result_reg", 32'(dut.result_reg), 32'h99);
    result = 8'h34;
    selecting_op1 = 1'b1;
    tick();
    chk("both_have_result", 32'(dut.have_result), 32'h0);
    chk("both_result_reg", 32'(dut.result_reg), 32'h34);
    result_valid = 1'b0;
    selecting_op1 = 1'b0;

    // Reset pulse mid-blink while idx2 is lit
    do_reset();
    operand2 = 4'h5;
    selecting_op2 = 1'b1;
    for (n = 1; n <= 10; n++) tick();
    chk("midblink_an_idx2", 32'(an), 32'b1011);
    chk("midblink_blink_on", 32'(dut.blink_on), 32'h0);
    reset = 1'b1;
    result = 8'hFF;
    result_valid = 1'b1;
    tick();
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_dp", 32'(dp), 32'h1);
    chk("mid_rst_refresh_cnt", 32'(dut.refresh_cnt), 32'h0);
    chk("mid_rst_digit_idx", 32'(dut.digit_idx), 32'h0);
    chk("mid_rst_blink_cnt", 32'(dut.blink_cnt), 32'h0);
    chk("mid_rst_blink_on", 32'(dut.blink_on), 32'h1);
    chk("mid_rst_have_result", 32'(dut.have_result), 32'h0);
    chk("mid_rst_result_reg", 32'(dut.result_reg), 32'h0);
    reset = 1'b0;
    result_valid = 1'b0;
    selecting_op2 = 1'b0;
    tick();
    chk("restart_dark_an", 32'(an), 32'hF);
    tick();
    chk("restart_idx0_an", 32'(an), 32'b1110);
    chk("restart_idx0_seg", 32'(seg), 32'h7F);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
